// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// Hits answer one cycle after the request; misses issue a single word read and fill the line.
module icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  flush,
    output logic                  inst_rdy,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_done,
    input  logic [INST_WIDTH-1:0] mem_data
);
    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int TAG_W  = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, RESP, MISS} state_t;

    state_t                  state_q, state_d;
    logic                    flushed_q, flushed_d;
    logic                    mem_req_q, mem_req_d;
    logic [WORD_W-1:0]       mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]       inst_pc_q, inst_pc_d;
    logic [INST_WIDTH-1:0]   inst_out_q, inst_out_d;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [INST_WIDTH-1:0]   data_q [LINES];

    logic [INDEX_WIDTH-1:0]  lk_idx, fill_idx;
    logic [TAG_W-1:0]        lk_tag, fill_tag;
    logic                    hit, fill_we;
    logic                    unused_pc;

    assign unused_pc = ^fetch_pc[1:0];
    assign lk_idx    = fetch_pc[INDEX_WIDTH+1:2];
    assign lk_tag    = fetch_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    // The outstanding miss address is held in mem_addr_q, so the fill uses it.
    assign fill_idx  = mem_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag  = mem_addr_q[WORD_W-1:INDEX_WIDTH];
    assign fill_we   = (state_q == MISS) && mem_done;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            flushed_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inst_pc_q  <= '0;
            inst_out_q <= '0;
            valid_q    <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            flushed_q  <= flushed_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_pc_q  <= inst_pc_d;
            inst_out_q <= inst_out_d;
            if (fill_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in && rdy_in && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        flushed_d  = flushed_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_pc_d  = inst_pc_q;
        inst_out_d = inst_out_q;
        case (state_q)
            IDLE: begin
                if (fetch_req && !flush) begin
                    inst_pc_d = fetch_pc[ADDR_WIDTH-1:2];
                    if (hit) begin
                        inst_out_d = data_q[lk_idx];
                        state_d    = RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc[ADDR_WIDTH-1:2];
                        state_d    = MISS;
                    end
                end
            end
            RESP: state_d = IDLE;
            MISS: begin
                if (flush) flushed_d = 1'b1;
                // A redirected miss still completes so the line gets filled.
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    flushed_d = 1'b0;
                    if (!flushed_q && !flush) begin
                        inst_out_d = mem_data;
                        state_d    = RESP;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_rdy = (state_q == RESP) && !flush;
        inst_out = inst_out_q;
        inst_pc  = {inst_pc_q, 2'b00};
        mem_req  = mem_req_q;
        mem_addr = {mem_addr_q, 2'b00};
    end
endmodule
